sparse_chunk_writer: RTL

Producer side of the sparse data-chunk write interface. Accepts a dense stream of 8-bit activation or weight bytes, one bus beat per cycle, and produces the compressed beats that the chunk storage consumes: a per-beat sparsemap plus the beat's nonzero bytes packed toward lane 0. It also owns the two-buffer ping-pong select and the per-beat write count, and applies back-pressure until the reading side releases a buffer. One instance sits in front of each of the IFM and filter chunk storages.

---
 rtl/sparse_chunk_pkg.sv | 34 +++
 rtl/sparse_beat_compactor.sv | 36 +++
 rtl/sparse_chunk_writer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/sparse_chunk_pkg.sv
// Shared types and helpers for the sparse chunk writer: popcount, beat-count
// derivation and the compressed beat record.
`ifndef BUS_SIZE
`define BUS_SIZE 4
`endif
`ifndef MEM_SIZE
`define MEM_SIZE 16
`endif

package sparse_chunk_pkg;

    localparam int MAX_LANES    = 64;
    localparam int DEF_BUS_SIZE = `BUS_SIZE;
    localparam int DEF_MEM_SIZE = `MEM_SIZE;

    typedef struct packed {
        logic [DEF_BUS_SIZE-1:0]   sparsemap;
        logic [DEF_BUS_SIZE*8-1:0] nz_data;
    } beat_t;

    function automatic int wr_dat_cyc_num(input int mem_size, input int bus_size);
        return mem_size / bus_size;
    endfunction

    function automatic int popcount(input logic [MAX_LANES-1:0] bits);
        int cnt;
        cnt = 0;
        for (int i = 0; i < MAX_LANES; i++) begin
            cnt = cnt + int'(bits[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/sparse_beat_compactor.sv
// Combinational compaction of one dense beat: sparsemap, per-lane prefix
// counts and the nonzero bytes packed toward lane 0.
module sparse_beat_compactor #(
    parameter  int BUS_SIZE = 4,
    localparam int PW       = $clog2(BUS_SIZE) + 1
) (
    input  logic [BUS_SIZE*8-1:0] dense_i,
    output logic [BUS_SIZE-1:0]   sparsemap_o,
    output logic [PW-1:0]         prefix_o [BUS_SIZE],
    output logic [BUS_SIZE*8-1:0] data_o
);

    always_comb begin
        logic [PW-1:0] acc;
        acc         = '0;
        sparsemap_o = '0;
        for (int i = 0; i < BUS_SIZE; i++) begin
            sparsemap_o[i] = |dense_i[i*8 +: 8];
            prefix_o[i]    = acc;
            acc            = acc + PW'(sparsemap_o[i]);
        end
    end

    // Lane i lands at output index prefix(i); nonzero lanes never collide.
    always_comb begin
        data_o = '0;
        for (int j = 0; j < BUS_SIZE; j++) begin
            for (int i = 0; i < BUS_SIZE; i++) begin
                if (sparsemap_o[i] && (prefix_o[i] == PW'(j))) begin
                    data_o[j*8 +: 8] = data_o[j*8 +: 8] | dense_i[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/sparse_chunk_writer.sv
// Producer side of the sparse chunk write path: compacts dense beats, counts
// beats per chunk and ping-pongs between two buffers with reader release.
module sparse_chunk_writer
    import sparse_chunk_pkg::*;
#(
    parameter  int BUS_SIZE       = `BUS_SIZE,
    parameter  int MEM_SIZE       = `MEM_SIZE,
    localparam int WR_DAT_CYC_NUM = wr_dat_cyc_num(MEM_SIZE, BUS_SIZE),
    localparam int CW             = (WR_DAT_CYC_NUM > 1) ? $clog2(WR_DAT_CYC_NUM) : 1,
    localparam int NW             = $clog2(MEM_SIZE) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [BUS_SIZE*8-1:0] dense_data_i,
    input  logic                  dense_valid_i,
    output logic                  dense_ready_o,
    output logic [BUS_SIZE-1:0]   wr_sparsemap_o,
    output logic [BUS_SIZE*8-1:0] wr_nonzero_data_o,
    output logic                  wr_valid_o,
    output logic [CW-1:0]         wr_count_o,
    output logic                  wr_sel_o,
    output logic                  chunk_done_o,
    output logic [NW-1:0]         chunk_nz_count_o,
    input  logic                  rd_release_i,
    input  logic                  rd_release_sel_i,
    output logic [1:0]            buf_full_o
);

    localparam int PW = $clog2(BUS_SIZE) + 1;

    logic [BUS_SIZE-1:0]   cmp_map;
    logic [PW-1:0]         cmp_prefix [BUS_SIZE];
    logic [BUS_SIZE*8-1:0] cmp_data;

    sparse_beat_compactor #(.BUS_SIZE(BUS_SIZE)) u_compactor (
        .dense_i     (dense_data_i),
        .sparsemap_o (cmp_map),
        .prefix_o    (cmp_prefix),
        .data_o      (cmp_data)
    );

    logic                  wr_sel_q,   wr_sel_d;
    logic [CW-1:0]         beat_cnt_q, beat_cnt_d;
    logic [NW-1:0]         nz_acc_q,   nz_acc_d;
    logic [1:0]            buf_full_q, buf_full_d;
    logic [BUS_SIZE-1:0]   map_q,      map_d;
    logic [BUS_SIZE*8-1:0] data_q,     data_d;
    logic                  valid_q,    valid_d;
    logic [CW-1:0]         count_q,    count_d;
    logic                  sel_q,      sel_d;
    logic                  done_q,     done_d;
    logic [NW-1:0]         nzc_q,      nzc_d;

    logic          accept;
    logic          last_beat;
    logic [NW-1:0] beat_pop;

    // A beat transfers on a cycle where dense_valid_i and dense_ready_o are both high.
    assign dense_ready_o = !rst_i && !buf_full_q[wr_sel_q];
    assign accept        = dense_valid_i && dense_ready_o;
    assign last_beat     = (beat_cnt_q == CW'(WR_DAT_CYC_NUM - 1));
    assign beat_pop      = NW'(popcount(MAX_LANES'(cmp_map)));

    always_comb begin
        wr_sel_d   = wr_sel_q;
        beat_cnt_d = beat_cnt_q;
        nz_acc_d   = nz_acc_q;
        buf_full_d = buf_full_q;
        map_d      = '0;
        data_d     = '0;
        valid_d    = 1'b0;
        count_d    = '0;
        sel_d      = 1'b0;
        done_d     = 1'b0;
        nzc_d      = '0;

        if (rd_release_i) begin
            buf_full_d[rd_release_sel_i] = 1'b0;
        end

        if (accept) begin
            map_d   = cmp_map;
            data_d  = cmp_data;
            valid_d = 1'b1;
            count_d = beat_cnt_q;
            sel_d   = wr_sel_q;
            if (last_beat) begin
                // Applied after the release so a same-buffer release loses.
                buf_full_d[wr_sel_q] = 1'b1;
                wr_sel_d             = !wr_sel_q;
                beat_cnt_d           = '0;
                nz_acc_d             = '0;
                done_d               = 1'b1;
                nzc_d                = nz_acc_q + beat_pop;
            end else begin
                beat_cnt_d = beat_cnt_q + CW'(1);
                nz_acc_d   = nz_acc_q + beat_pop;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_sel_q   <= 1'b0;
            beat_cnt_q <= '0;
            nz_acc_q   <= '0;
            buf_full_q <= '0;
            map_q      <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            count_q    <= '0;
            sel_q      <= 1'b0;
            done_q     <= 1'b0;
            nzc_q      <= '0;
        end else begin
            wr_sel_q   <= wr_sel_d;
            beat_cnt_q <= beat_cnt_d;
            nz_acc_q   <= nz_acc_d;
            buf_full_q <= buf_full_d;
            map_q      <= map_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            count_q    <= count_d;
            sel_q      <= sel_d;
            done_q     <= done_d;
            nzc_q      <= nzc_d;
        end
    end

    assign wr_sparsemap_o    = map_q;
    assign wr_nonzero_data_o = data_q;
    assign wr_valid_o        = valid_q;
    assign wr_count_o        = count_q;
    assign wr_sel_o          = sel_q;
    assign chunk_done_o      = done_q;
    assign chunk_nz_count_o  = nzc_q;
    assign buf_full_o        = buf_full_q;

endmodule
